// File: rtl/mem_pkg.sv
// Constants and the state encoding shared by the backing memory
// controller and the cache side that talks to it.
package mem_pkg;
    localparam int LATENCY    = 5;
    localparam int BURST_LEN  = 4;
    localparam int LINE_BYTES = 16;
    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = WORD_W / 8;
    localparam int LINE_WORDS = LINE_BYTES / WORD_BYTES;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_WRITE = 2'd3
    } mem_state_e;
endpackage

// File: rtl/mem_word_array.sv
// Word storage: single port, asynchronous read, synchronous write.
// Contents are intentionally not reset.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/backing_memory_ctrl.sv
// Fixed-latency backing memory: line-fill reads returned as a BURST_LEN
// beat burst, single-word writes committed after the same wait.
module backing_memory_ctrl #(
    parameter int LATENCY     = mem_pkg::LATENCY,
    parameter int DEPTH_WORDS = 4096,
    parameter int BURST_LEN   = mem_pkg::BURST_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_last,
    output logic        mem_busy
);
    import mem_pkg::*;

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int OFS_W  = $clog2(LINE_WORDS);
    localparam int WCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    mem_state_e        state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [BEAT_W-1:0] beat;
    logic [IDX_W-1:0]  word_q;
    logic [31:0]       wdata_q;
    logic              is_write;

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  arr_addr;
    logic [31:0]       arr_rdata;
    logic              arr_we;
    logic              unused_addr;

    // Byte offset and anything above the array size never reach the array.
    assign unused_addr = &{1'b0, mem_addr[31:IDX_W+2], mem_addr[1:0]};

    // Line base plus beat, wrapping inside the array; no critical-word-first.
    assign rd_idx   = {word_q[IDX_W-1:OFS_W], OFS_W'(0)} + IDX_W'(beat);
    assign arr_we   = (state == ST_WRITE);
    assign arr_addr = arr_we ? word_q : rd_idx;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    assign mem_rdata = (state == ST_BURST) ? arr_rdata : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            beat      <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            is_write  <= 1'b0;
            mem_ready <= 1'b0;
            mem_last  <= 1'b0;
            mem_busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_read_en || mem_write_en) begin
                        word_q   <= mem_addr[IDX_W+1:2];
                        wdata_q  <= mem_wdata;
                        is_write <= mem_write_en;
                        wait_cnt <= '0;
                        beat     <= '0;
                        mem_busy <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WCNT_W'(LATENCY - 1)) begin
                        mem_ready <= 1'b1;
                        mem_last  <= is_write || (BURST_LEN == 1);
                        state     <= is_write ? ST_WRITE : ST_BURST;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (beat == BEAT_W'(BURST_LEN - 1)) begin
                        beat      <= '0;
                        mem_ready <= 1'b0;
                        mem_last  <= 1'b0;
                        mem_busy  <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        beat     <= beat + 1'b1;
                        mem_last <= (beat == BEAT_W'(BURST_LEN - 2));
                    end
                end
                ST_WRITE: begin
                    mem_ready <= 1'b0;
                    mem_last  <= 1'b0;
                    mem_busy  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    mem_last  <= 1'b0;
                    mem_busy  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_backing_memory_ctrl.sv
// Directed bench for backing_memory_ctrl: a transaction table with
// per-cycle busy/ready/last masks and beat data, plus reset-abort sequences.
module tb_backing_memory_ctrl;
    localparam int LAT = 5;
    localparam int BL  = 4;

    logic        clk;
    logic        reset;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_last;
    logic        mem_busy;

    int total;
    int passed;

    backing_memory_ctrl #(.LATENCY(LAT), .DEPTH_WORDS(4096), .BURST_LEN(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read_en (mem_read_en),
        .mem_write_en(mem_write_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_last    (mem_last),
        .mem_busy    (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [3:0][31:0]  exp;
        int                pulse;
        string             name;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0][31:0] exp,
                                input int pulse, input string name);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp = exp; v.pulse = pulse; v.name = name;
        return v;
    endfunction

    // Entered at a negedge (cycle 0); leaves at the negedge of the last,
    // IDLE, cycle so the next request tests zero turnaround.
    task automatic txn(input vec_t v);
        int occ;
        int busy_tr, ready_tr, last_tr, busy_m, ready_m, last_m;
        logic [31:0] idle_or;
        logic [3:0][31:0] got;
        occ = v.wr ? (1 + LAT + 1) : (1 + LAT + BL);
        busy_tr = 0; ready_tr = 0; last_tr = 0; idle_or = 32'h0; got = '0;
        mem_read_en = v.rd; mem_write_en = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
        @(negedge clk);
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        for (int k = 1; k <= occ; k++) begin
            busy_tr  |= int'(mem_busy)  << k;
            ready_tr |= int'(mem_ready) << k;
            last_tr  |= int'(mem_last)  << k;
            if (!v.wr && k > LAT && k <= LAT + BL) got[k-LAT-1] = mem_rdata;
            else idle_or |= mem_rdata;
            if (k == v.pulse) begin
                mem_read_en = 1'b1; mem_addr = 32'h100;
            end else begin
                mem_read_en = 1'b0;
            end
            if (k < occ) @(negedge clk);
        end
        mem_read_en = 1'b0;
        busy_m = ((1 << occ) - 1) & ~1;
        if (v.wr) begin
            ready_m = 1 << (LAT + 1);
            last_m  = 1 << (LAT + 1);
        end else begin
            ready_m = ((1 << BL) - 1) << (LAT + 1);
            last_m  = 1 << (LAT + BL);
        end
        chk({v.name, " busy"},  busy_tr,  busy_m);
        chk({v.name, " ready"}, ready_tr, ready_m);
        chk({v.name, " last"},  last_tr,  last_m);
        chk({v.name, " rdata_idle"}, idle_or, 32'h0);
        if (!v.wr)
            for (int b = 0; b < BL; b++)
                chk($sformatf("%s beat%0d", v.name, b), got[b], v.exp[b]);
    endtask

    function automatic vec_t wr_v(input logic [31:0] a, input logic [31:0] d, input string n);
        return mk(1'b0, 1'b1, a, d, '0, 0, n);
    endfunction

    function automatic vec_t rd_v(input logic [31:0] a, input logic [3:0][31:0] e, input int p,
                                  input string n);
        return mk(1'b1, 1'b0, a, 32'h0, e, p, n);
    endfunction

    localparam logic [31:0] A0 = 32'hA000_00A0, A1 = 32'hA100_00A1;
    localparam logic [31:0] A2 = 32'hA200_00A2, A3 = 32'hA300_00A3;

    initial begin
        total = 0; passed = 0;
        reset = 1'b1; mem_read_en = 1'b0; mem_write_en = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0;

        vt.push_back(wr_v(32'h40, A0, "pre_a0"));
        vt.push_back(wr_v(32'h44, A1, "pre_a1"));
        vt.push_back(wr_v(32'h48, A2, "pre_a2"));
        vt.push_back(wr_v(32'h4F, A3, "pre_a3_lowbits"));
        vt.push_back(rd_v(32'h48, {A3, A2, A1, A0}, 0, "rd_0x48"));
        vt.push_back(wr_v(32'h100, 32'h1111_0100, "pre_100"));
        vt.push_back(wr_v(32'h108, 32'h1111_0108, "pre_108"));
        vt.push_back(wr_v(32'h10C, 32'h1111_010C, "pre_10c"));
        vt.push_back(wr_v(32'h104, 32'h1234_5678, "wr_104"));
        vt.push_back(rd_v(32'h100, {32'h1111_010C, 32'h1111_0108, 32'h1234_5678, 32'h1111_0100},
                          0, "rd_100"));
        vt.push_back(wr_v(32'h24, 32'h0000_0024, "pre_24"));
        vt.push_back(wr_v(32'h28, 32'h0000_0028, "pre_28"));
        vt.push_back(wr_v(32'h2C, 32'h0000_002C, "pre_2c"));
        vt.push_back(mk(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, '0, 0, "rw_both_0x20"));
        vt.push_back(rd_v(32'h20, {32'h2C, 32'h28, 32'h24, 32'hCAFE_F00D}, 0, "rd_20"));
        vt.push_back(wr_v(32'h3FF0, 32'hF0F0_0FF0, "pre_ffc"));
        vt.push_back(wr_v(32'h3FF4, 32'hF0F0_0FF4, "pre_ffd"));
        vt.push_back(wr_v(32'h3FF8, 32'hF0F0_0FF8, "pre_ffe"));
        vt.push_back(wr_v(32'h3FFC, 32'hF0F0_0FFC, "pre_fff"));
        vt.push_back(rd_v(32'h3FFF0, {32'hF0F0_0FFC, 32'hF0F0_0FF8, 32'hF0F0_0FF4, 32'hF0F0_0FF0},
                          0, "rd_wrap"));
        vt.push_back(rd_v(32'h48, {A3, A2, A1, A0}, 3, "rd_busy_ignore"));

        repeat (2) @(negedge clk);
        chk("reset busy",  {31'h0, mem_busy},  32'h0);
        chk("reset ready", {31'h0, mem_ready}, 32'h0);
        chk("reset last",  {31'h0, mem_last},  32'h0);
        chk("reset rdata", mem_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i]) txn(vt[i]);

        // Reset during the WAIT of a write: nothing is committed.
        @(negedge clk);
        mem_write_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_write_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrabort busy_pre", {31'h0, mem_busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk("wrabort busy",  {31'h0, mem_busy},  32'h0);
        chk("wrabort ready", {31'h0, mem_ready}, 32'h0);
        chk("wrabort last",  {31'h0, mem_last},  32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(rd_v(32'h40, {A3, A2, A1, A0}, 0, "rd_after_wrabort"));

        // Reset on burst beat 1: outputs drop at once, storage survives.
        @(negedge clk);
        mem_read_en = 1'b1; mem_addr = 32'h48;
        @(negedge clk);
        mem_read_en = 1'b0;
        repeat (6) @(negedge clk);
        chk("rdabort ready_pre", {31'h0, mem_ready}, 32'h1);
        chk("rdabort beat1", mem_rdata, A1);
        reset = 1'b1;
        #1;
        chk("rdabort busy",  {31'h0, mem_busy},  32'h0);
        chk("rdabort ready", {31'h0, mem_ready}, 32'h0);
        chk("rdabort rdata", mem_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rdabort idle", {31'h0, mem_busy}, 32'h0);
        txn(rd_v(32'h48, {A3, A2, A1, A0}, 0, "rd_after_rdabort"));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
